// File: rtl/barrier_table_ctl_if.sv
// Barrier request/kill/release bundle between warp control, barrier table and scheduler.
// The master drives arrivals and kills; the slave (barrier_table_ctl) drives stall/release state.
interface barrier_table_ctl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  logic                 bar_valid;
  logic [NW_BITS-1:0]   bar_wid;
  logic [NB_BITS-1:0]   bar_id;
  logic [NW_BITS-1:0]   bar_size_m1;
  logic                 kill_valid;
  logic [NW_BITS-1:0]   kill_wid;
  logic [NUM_WARPS-1:0] stalled_mask;
  logic                 release_valid;
  logic [NB_BITS-1:0]   release_id;
  logic [NUM_WARPS-1:0] release_wmask;
  logic                 dup_error;
  logic [31:0]          perf_stall_cycles;

  modport master (
    output bar_valid, bar_wid, bar_id, bar_size_m1, kill_valid, kill_wid,
    input  stalled_mask, release_valid, release_id, release_wmask, dup_error, perf_stall_cycles
  );

  modport slave (
    input  bar_valid, bar_wid, bar_id, bar_size_m1, kill_valid, kill_wid,
    output stalled_mask, release_valid, release_id, release_wmask, dup_error, perf_stall_cycles
  );
endinterface

// File: rtl/barrier_table_ctl.sv
// Per-core barrier table: stalls arriving warps and pulses a release when a barrier fills.
// Optional stall-cycle performance counter is built when BARRIER_PERF_EN is defined.
module barrier_table_ctl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  barrier_table_ctl_if.slave   bif
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int CW      = NW_BITS + 1;

  logic                 busy_q  [NUM_BARRIERS];
  logic                 busy_k  [NUM_BARRIERS];
  logic                 busy_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_k [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] wmask_d [NUM_BARRIERS];
  logic [CW-1:0]        cnt_q   [NUM_BARRIERS];
  logic [CW-1:0]        cnt_k   [NUM_BARRIERS];
  logic [CW-1:0]        cnt_d   [NUM_BARRIERS];
  logic [NW_BITS-1:0]   size_q  [NUM_BARRIERS];
  logic [NW_BITS-1:0]   size_d  [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic                 release_valid_q, release_valid_d;
  logic [NB_BITS-1:0]   release_id_q, release_id_d;
  logic [NUM_WARPS-1:0] release_wmask_q, release_wmask_d;
  logic                 dup_q, dup_d;

  logic [NUM_WARPS-1:0] kill_oh, bar_oh;
  assign kill_oh = NUM_WARPS'(1) << bif.kill_wid;
  assign bar_oh  = NUM_WARPS'(1) << bif.bar_wid;

  // Kill is resolved first so a same-cycle arrival sees the post-kill table.
  for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_kill
    logic hit;
    assign hit         = bif.kill_valid && wmask_q[gi][bif.kill_wid];
    assign wmask_k[gi] = hit ? (wmask_q[gi] & ~kill_oh) : wmask_q[gi];
    assign cnt_k[gi]   = hit ? (cnt_q[gi] - CW'(1)) : cnt_q[gi];
    assign busy_k[gi]  = hit ? (cnt_q[gi] != CW'(1)) : busy_q[gi];
  end

  always_comb begin
    logic [NW_BITS-1:0] eff_size;
    eff_size        = '0;
    release_valid_d = 1'b0;
    release_id_d    = '0;
    release_wmask_d = '0;
    dup_d           = dup_q;
    stalled_d       = '0;
    for (int e = 0; e < NUM_BARRIERS; e++) begin
      busy_d[e]  = busy_k[e];
      wmask_d[e] = wmask_k[e];
      cnt_d[e]   = cnt_k[e];
      size_d[e]  = size_q[e];
    end
    if (bif.bar_valid && !(bif.kill_valid && (bif.kill_wid == bif.bar_wid))) begin
      if (wmask_k[bif.bar_id][bif.bar_wid]) begin
        dup_d = 1'b1;
      end else begin
        eff_size = busy_k[bif.bar_id] ? size_q[bif.bar_id] : bif.bar_size_m1;
        if (cnt_k[bif.bar_id] == {1'b0, eff_size}) begin
          release_valid_d         = 1'b1;
          release_id_d            = bif.bar_id;
          release_wmask_d         = wmask_k[bif.bar_id] | bar_oh;
          busy_d[bif.bar_id]      = 1'b0;
          wmask_d[bif.bar_id]     = '0;
          cnt_d[bif.bar_id]       = '0;
        end else begin
          busy_d[bif.bar_id]  = 1'b1;
          wmask_d[bif.bar_id] = wmask_k[bif.bar_id] | bar_oh;
          cnt_d[bif.bar_id]   = cnt_k[bif.bar_id] + CW'(1);
          if (!busy_k[bif.bar_id]) size_d[bif.bar_id] = bif.bar_size_m1;
        end
      end
    end
    for (int e = 0; e < NUM_BARRIERS; e++) stalled_d = stalled_d | wmask_d[e];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NUM_BARRIERS; e++) begin
        busy_q[e]  <= 1'b0;
        wmask_q[e] <= '0;
        cnt_q[e]   <= '0;
        size_q[e]  <= '0;
      end
      stalled_q       <= '0;
      release_valid_q <= 1'b0;
      release_id_q    <= '0;
      release_wmask_q <= '0;
      dup_q           <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_BARRIERS; e++) begin
        busy_q[e]  <= busy_d[e];
        wmask_q[e] <= wmask_d[e];
        cnt_q[e]   <= cnt_d[e];
        size_q[e]  <= size_d[e];
      end
      stalled_q       <= stalled_d;
      release_valid_q <= release_valid_d;
      release_id_q    <= release_id_d;
      release_wmask_q <= release_wmask_d;
      dup_q           <= dup_d;
    end
  end

  assign bif.stalled_mask  = stalled_q;
  assign bif.release_valid = release_valid_q;
  assign bif.release_id    = release_id_q;
  assign bif.release_wmask = release_wmask_q;
  assign bif.dup_error     = dup_q;

`ifdef BARRIER_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    logic [32:0] sum;
    sum = {1'b0, perf_q};
    for (int w = 0; w < NUM_WARPS; w++) sum = sum + 33'(stalled_q[w]);
    perf_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign bif.perf_stall_cycles = perf_q;
`else
  assign bif.perf_stall_cycles = '0;
`endif
endmodule

// File: doc/barrier_table_ctl.md
Name: barrier_table_ctl

Overview:
- Per-core barrier scheduler. Consumes the barrier requests that the warp-control path issues on `warp_ctl_if` (`valid`, `wid`, `barrier.id`, `barrier.size_m1`).
- Tracks which warps have arrived at each local barrier and stalls those warps.
- Releases all participants with a one-cycle release pulse once the expected warp count is reached.
- Sits between the warp-control commit path and the warp scheduler's stall/unlock logic.

Parameters:
- NUM_WARPS, 4, number of hardware warps; NW_BITS = max(1, CLOG2(NUM_WARPS)).
- NUM_BARRIERS, 4, number of barrier table entries; NB_BITS = max(1, CLOG2(NUM_BARRIERS)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- bar_valid  in  1  barrier arrival request (single-cycle; no backpressure).
- bar_wid  in  NW_BITS  arriving warp id.
- bar_id  in  NB_BITS  barrier id.
- bar_size_m1  in  NW_BITS  expected participating warps minus 1.
- kill_valid  in  1  warp termination or flush notification.
- kill_wid  in  NW_BITS  warp being killed.
- stalled_mask  out  NUM_WARPS  warps currently blocked at any barrier (registered).
- release_valid  out  1  barrier release pulse (registered).
- release_id  out  NB_BITS  released barrier id.
- release_wmask  out  NUM_WARPS  warps to unlock, including the last arriver.
- dup_error  out  1  sticky flag: a warp arrived twice at the same barrier.
- perf_stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Per-entry state:
  - `busy`
  - `wmask[NUM_WARPS]`
  - `cnt[NW_BITS+1]` (number of arrivals so far)
  - `size_m1[NW_BITS]`, latched from the first arrival.
- Reset values:
  - All entries: `busy`, `wmask`, `cnt` = 0.
  - `stalled_mask` = 0, `release_valid` = 0, `release_id` = 0, `release_wmask` = 0, `dup_error` = 0, `perf_stall_cycles` = 0.
  - Reset has priority over every same-cycle input.
  - Reset asserted mid-barrier drops all waiting warps; no release is emitted.
- Arrival with `bar_valid` in cycle N, entry e = `bar_id`:
  - **Duplicate:** if `wmask[bar_wid]` is already set, the request is ignored and `dup_error` is set from N+1.
  - **First arrival** (`busy` = 0): `busy` <= 1 and `size_m1` <= `bar_size_m1`. Later arrivals' `bar_size_m1` values are ignored.
  - **Completing arrival** (`cnt` == latched `size_m1`, with `size_m1` from this cycle's value if first):
    - In N+1: `release_valid` = 1, `release_id` = e, `release_wmask` = old `wmask` | onehot(`bar_wid`).
    - The entry is cleared (`busy`, `wmask`, `cnt` = 0).
    - The participants' `stalled_mask` bits are 0 in N+1.
    - The completing warp never appears in `stalled_mask`.
  - **Otherwise:** `wmask[bar_wid]` <= 1, `cnt` <= `cnt` + 1, and `stalled_mask[bar_wid]` = 1 from N+1.
- Latency: arrival to release is exactly 1 cycle. At most one release per cycle, since there is at most one arrival per cycle.
- `release_valid` is a single-cycle pulse and returns to 0 the following cycle unless another completion occurs. Back-to-back completions on different or same ids in consecutive cycles produce consecutive pulses.
- `size_m1` = 0: the first arrival is also the completing arrival. Release occurs in N+1 with a onehot mask; no stall is recorded.
- Kill in cycle N, warp w:
  - Every entry with `wmask[w]` set clears that bit and decrements `cnt`.
  - An entry whose `cnt` reaches 0 becomes not busy.
  - `stalled_mask[w]` = 0 from N+1.
  - Kill is applied before a same-cycle arrival.
  - A same-cycle arrival from w itself is dropped.
  - A same-cycle arrival from another warp is evaluated against the post-kill `cnt`.
- `stalled_mask` = OR of all entries' `wmask` (registered view).

Optional Feature:
- Macro: BARRIER_PERF_EN.
- Defined: `perf_stall_cycles` increments each cycle by popcount(`stalled_mask`). It saturates at 32'hFFFFFFFF and is cleared by reset.
- Undefined: the counter logic is absent and `perf_stall_cycles` is tied to 0.

Test Plan:
- **Basic release:** NUM_WARPS=4; arrivals (wid0, id1, size_m1=2) @N, (wid2, id1) @N+2, (wid3, id1) @N+4.
  - `stalled_mask` = 0001 @N+1, 0101 @N+3.
  - `release_valid` @N+5 with `release_id` = 1, `release_wmask` = 1101; `stalled_mask` = 0 @N+5.
- **Single-warp barrier:** (wid1, id0, size_m1=0) @N -> release @N+1 with `release_wmask` = 0010; `stalled_mask` stays 0.
- **Duplicate arrival:** (wid0, id2, size_m1=1) twice -> no release; `dup_error` = 1; `stalled_mask` = 0001. Then wid3 arrives at id2 -> release with `release_wmask` = 1001.
- **Kill of waiting warp:** wid0 and wid1 waiting on id0 (size_m1=3); kill wid1 -> `stalled_mask` = 0001. Then wid2 and wid3 arrive -> no release (`cnt` = 3 < 4) until another warp arrives.
- **Reset mid-operation:** two warps waiting, reset for 1 cycle -> all outputs 0 and no release. A fresh size_m1=0 arrival releases in the next cycle.
- **Perf counter (BARRIER_PERF_EN):** 2 warps stalled for 10 cycles -> `perf_stall_cycles` = 20. With the macro undefined -> reads 0.
